sr_cmd_gen: RTL
===============

# sr_cmd_gen

Command generator that sits directly upstream of the SR flip-flop stage. It turns two raw, bouncing push-button inputs into clean, mutually exclusive, fixed-width `s` and `r` pulses. Each channel is synchronized and debounced, then press-edge detected and arbitrated by a small FSM, so the downstream stage never sees `s` and `r` high together.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive stable synchronized cycles required before the debounced level changes (≥1).
- `PULSE_CYCLES`, default 2: cycles `s`/`r` stays high per command (≥1).
- `GAP_CYCLES`, default 1: idle cycles forced after each pulse before a new command is accepted (≥0).

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `btn_s` in 1: raw set button, asynchronous to `clk`.
- `btn_r` in 1: raw reset button, asynchronous to `clk`.
- `s` out 1: registered set command to the SR stage.
- `r` out 1: registered reset command to the SR stage.
- `busy` out 1: high whenever the FSM is not IDLE.
- `conflict` out 1: one-cycle pulse when both presses are detected in the same IDLE cycle.

## Operation
- Per channel: 2-flop synchronizer, then debouncer. While the synchronized value ≠ debounced level, a counter increments; any cycle where they are equal clears it. When the counter reaches `DEB_CYCLES-1` with inputs still differing, the debounced level flips on the next edge and the counter clears.
- Press request = debounced rising edge (level high, previous-cycle level low). Releases are debounced but generate nothing.
- FSM states:
  - IDLE: set-request only → S_PULSE; reset-request only → R_PULSE; both → stay IDLE and pulse `conflict`.
  - S_PULSE: `s`=1 for `PULSE_CYCLES` cycles, then → GAP (or IDLE if `GAP_CYCLES`=0).
  - R_PULSE: `r`=1 for `PULSE_CYCLES` cycles, then → GAP (or IDLE if `GAP_CYCLES`=0).
  - GAP: `GAP_CYCLES` cycles, then → IDLE.
- Requests arriving outside IDLE are dropped, not queued.
- `s` and `r` are never simultaneously 1 in any cycle.
- Pulse/gap counter is `$clog2(max(PULSE_CYCLES,GAP_CYCLES)+1)` bits. Debounce counter is `$clog2(DEB_CYCLES+1)` bits.
- Reset values: `s`=0, `r`=0, `busy`=0, `conflict`=0, all sync/debounce flops 0, state IDLE.
- A button held through reset release counts as a press: one pulse is issued after debounce.

## Timing
- Raw input rises and is stable before edge k:
  - synchronized high at k+2;
  - debounced high at k+2+`DEB_CYCLES`;
  - request combinational in that cycle;
  - `s`/`r` high from k+3+`DEB_CYCLES`.
- With defaults: pulse high in cycles k+7 and k+8, GAP in k+9, IDLE from k+10.
- `busy` rises in the same cycle as `s`/`r` and falls on entry to IDLE.
- `conflict` is registered and is high exactly the cycle after the simultaneous request.
- A bounce (sync toggles back) before the count completes restarts the count from 0.
- Reset mid-pulse: `s`/`r`/`busy` drop immediately (asynchronously). No pulse resumes after release.

## Configuration
- `SR_CMD_GEN_CONFLICT_CNT_EN` defined: adds output `conflict_cnt` out 8, a saturating count of `conflict` pulses. It resets to 0 and holds at 255.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `sr_cmd_pkg` holds:
  - the FSM state enum (IDLE, S_PULSE, R_PULSE, GAP);
  - default constants for `DEB_CYCLES`, `PULSE_CYCLES`, `GAP_CYCLES`;
  - the conflict-counter width (8).
- Sub-module `sr_debounce` (synchronizer + debouncer + edge detect, parameter `DEB_CYCLES`, outputs level and press) is instantiated twice. The FSM lives in `sr_cmd_gen`.

## Test plan
- Clean press: `btn_s` high at cycle 10, held with defaults → `s`=1 in cycles 17–18, `busy`=1 in 17–19, `r` stays 0.
- Bounce: `btn_r` toggles 1,0,1 on consecutive cycles, then holds → one `r` pulse only, starting 7 cycles after the final rise.
- Simultaneous press: both buttons rise the same cycle → no `s`/`r` pulse, `conflict`=1 for exactly one cycle. With the macro defined, `conflict_cnt` = 1.
- Busy drop: `btn_s` press, then a `btn_r` press whose request falls in S_PULSE or GAP → only the `s` pulse is issued, and the `r` request is lost.
- Reset mid-pulse: assert `rst_n`=0 while `s`=1 → `s`=0 with no clock edge. After release with buttons low, there is no activity.
- Saturation (macro defined): 300 simultaneous-press events → `conflict_cnt` = 255.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// Shared types and default constants for the SR command generator.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    S_PULSE = 2'd1,
    R_PULSE = 2'd2,
    GAP     = 2'd3
  } state_e;

  localparam int DEB_CYCLES_DEF   = 4;
  localparam int PULSE_CYCLES_DEF = 2;
  localparam int GAP_CYCLES_DEF   = 1;
  localparam int CONFLICT_CNT_W   = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// One button channel: 2-flop synchronizer, stability-count debouncer and
// press (debounced rising edge) detector.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      // synchronizer stage boundary
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      level_q <= level;
      // any cycle of agreement restarts the stability count
      if (sync_p1 != level) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced, arbitrated S/R pulse generator for the SR flip-flop stage.
// Optional build macro SR_CMD_GEN_CONFLICT_CNT_EN adds a saturating conflict counter.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_s,
  input  logic btn_r,
  output logic s,
  output logic r,
  output logic busy,
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
  output logic conflict,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`else
  output logic conflict
`endif
);

  localparam int CW = $clog2(max2(PULSE_CYCLES, GAP_CYCLES) + 1);

  logic          req_s;
  logic          req_r;
  logic          lvl_s;
  logic          lvl_r;
  logic          unused_lvl;
  state_e        state;
  state_e        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          conflict_nxt;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_s),
    .level (lvl_s),
    .press (req_s)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_r),
    .level (lvl_r),
    .press (req_r)
  );

  // Debounced levels are only needed for edge detection inside the channel.
  assign unused_lvl = lvl_s ^ lvl_r;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    conflict_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req_s && req_r) begin
          conflict_nxt = 1'b1;
        end else if (req_s) begin
          state_nxt = S_PULSE;
        end else if (req_r) begin
          state_nxt = R_PULSE;
        end
      end
      S_PULSE, R_PULSE: begin
        if (cnt == CW'(PULSE_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      s        <= (state_nxt == S_PULSE);
      r        <= (state_nxt == R_PULSE);
      busy     <= (state_nxt != IDLE);
      conflict <= conflict_nxt;
    end
  end

`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != {CONFLICT_CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CONFLICT_CNT_W'(1);
    end
  end
`endif

endmodule
